// File: rtl/wb_gpio_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// wb_gpio_irq_ctrl_if
// Wishbone classic slave bundle for the GPIO / interrupt controller.
//
// Signals (named from the slave's point of view):
//   wbs_cyc_i  bus cycle in progress
//   wbs_stb_i  strobe; together with cyc, it is the request "valid"
//   wbs_we_i   1 = write, 0 = read
//   wbs_sel_i  byte-lane enables for writes
//   wbs_adr_i  byte address
//   wbs_dat_i  write data
//   wbs_ack_o  one-cycle acknowledge; this is the "ready/done" strobe
//   wbs_dat_o  read data, valid only while wbs_ack_o is high, else 0
//
// Handshake: a request is cyc & stb & address decode match while ack is low.
// It is accepted on that clock edge and ack is high for exactly the
// following cycle. The master keeps cyc/stb/we/sel/adr/dat stable until it
// sees ack. If stb is still held when ack is seen, the slave treats it as a
// new request on the next edge, so a held strobe gets one ack every 2 cycles.
// ---------------------------------------------------------------------------
interface wb_gpio_irq_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// wb_gpio_irq_ctrl
// Wishbone slave owning the user IO pads: output data, per-pad output
// enable (active-low), synchronized input readback and per-pad
// edge-triggered interrupts with write-1-to-clear status.
//
// Parameters:
//   BASE_ADDR  slave base; decode compares address bits [31:8]
//   NIO        pad count, 1..32
//
// Ports:
//   wb_clk_i   sole clock
//   wb_rst_i   asynchronous active-high reset
//   bus        Wishbone slave modport (see wb_gpio_irq_ctrl_if)
//   gpio_in    raw asynchronous pad inputs
//   gpio_out   pad output data
//   gpio_oeb   pad output enable, active-low (reset: all pads are inputs)
//   irq_o      level interrupt, |(IRQ_STATUS & IRQ_EN)
//
// Register map (word offsets from the base):
//   0x00 DATA_OUT  rw      0x0C IRQ_EN      rw
//   0x04 OEB       rw      0x10 IRQ_EDGE    rw (0 rising, 1 falling)
//   0x08 DATA_IN   ro      0x14 IRQ_STATUS  W1C, sticky
//   0x18..0xFC read 0, writes ignored, still acknowledged.
// ---------------------------------------------------------------------------
module wb_gpio_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NIO       = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_gpio_irq_ctrl_if.slave    bus,
  input  logic [NIO-1:0]       gpio_in,
  output logic [NIO-1:0]       gpio_out,
  output logic [NIO-1:0]       gpio_oeb,
  output logic                 irq_o
);

  localparam logic [5:0] OFF_DATA_OUT   = 6'd0;
  localparam logic [5:0] OFF_OEB        = 6'd1;
  localparam logic [5:0] OFF_DATA_IN    = 6'd2;
  localparam logic [5:0] OFF_IRQ_EN     = 6'd3;
  localparam logic [5:0] OFF_IRQ_EDGE   = 6'd4;
  localparam logic [5:0] OFF_IRQ_STATUS = 6'd5;

  logic           r_ack;
  logic [31:0]    r_dat;
  logic [NIO-1:0] r_out;
  logic [NIO-1:0] r_oeb;
  logic [NIO-1:0] r_en;
  logic [NIO-1:0] r_edge;
  logic [NIO-1:0] r_status;
  logic [NIO-1:0] r_sync1;
  logic [NIO-1:0] r_sync2;
  logic [NIO-1:0] r_prev;

  logic           w_match;
  logic           w_req;
  logic           w_wr;
  logic           w_rd;
  logic [5:0]     w_word;
  logic [31:0]    w_lane_mask;
  logic [NIO-1:0] w_wmask;
  logic [NIO-1:0] w_wdata;
  logic [NIO-1:0] w_rise;
  logic [NIO-1:0] w_fall;
  logic [NIO-1:0] w_set;
  logic [NIO-1:0] w_clr;
  logic [31:0]    w_rdata;
  logic           w_unused;

  // ack is registered, so gating the request with !r_ack forces a one-cycle
  // gap after every acknowledge even when the master keeps stb asserted.
  assign w_match = (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_req   = bus.wbs_cyc_i & bus.wbs_stb_i & w_match & ~r_ack;
  assign w_wr    = w_req & bus.wbs_we_i;
  assign w_rd    = w_req & ~bus.wbs_we_i;
  assign w_word  = bus.wbs_adr_i[7:2];

  assign w_lane_mask = {{8{bus.wbs_sel_i[3]}}, {8{bus.wbs_sel_i[2]}},
                        {8{bus.wbs_sel_i[1]}}, {8{bus.wbs_sel_i[0]}}};
  assign w_wmask = w_lane_mask[NIO-1:0];
  assign w_wdata = bus.wbs_dat_i[NIO-1:0];

  // Edge detection works on the synchronized copy and its one-cycle delay.
  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign w_set  = r_en & ((w_rise & ~r_edge) | (w_fall & r_edge));
  assign w_clr  = (w_wr && (w_word == OFF_IRQ_STATUS)) ? (w_wdata & w_wmask)
                                                        : '0;

  // Read mux: bits at or above NIO stay zero.
  always_comb begin
    w_rdata = '0;
    case (w_word)
      OFF_DATA_OUT:   w_rdata[NIO-1:0] = r_out;
      OFF_OEB:        w_rdata[NIO-1:0] = r_oeb;
      OFF_DATA_IN:    w_rdata[NIO-1:0] = r_sync2;
      OFF_IRQ_EN:     w_rdata[NIO-1:0] = r_en;
      OFF_IRQ_EDGE:   w_rdata[NIO-1:0] = r_edge;
      OFF_IRQ_STATUS: w_rdata[NIO-1:0] = r_status;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_out    <= '0;
      r_oeb    <= '1;
      r_en     <= '0;
      r_edge   <= '0;
      r_status <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_wr) begin
        case (w_word)
          OFF_DATA_OUT: r_out  <= (r_out  & ~w_wmask) | (w_wdata & w_wmask);
          OFF_OEB:      r_oeb  <= (r_oeb  & ~w_wmask) | (w_wdata & w_wmask);
          OFF_IRQ_EN:   r_en   <= (r_en   & ~w_wmask) | (w_wdata & w_wmask);
          OFF_IRQ_EDGE: r_edge <= (r_edge & ~w_wmask) | (w_wdata & w_wmask);
          default: ;
        endcase
      end
      // A new edge in the same cycle as a clear keeps the flag set.
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dat;
  assign gpio_out      = r_out;
  assign gpio_oeb      = r_oeb;
  assign irq_o         = |(r_status & r_en);

  // Address byte bits and data/lane bits above NIO carry no information.
  assign w_unused = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i, w_lane_mask};

endmodule
